// File: rtl/rect_fill_ctrl.sv
// rect_fill_ctrl: clipped rectangle fill engine with CPU-priority frame buffer write arbitration
module rect_fill_ctrl #(
  parameter int WIDTH        = 160,
  parameter int HEIGHT       = 120,
  parameter int BITSPERPIXEL = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic [7:0]              x0,
  input  logic [7:0]              y0,
  input  logic [7:0]              x1,
  input  logic [7:0]              y1,
  input  logic [BITSPERPIXEL-1:0] fill_color,
  output logic                    busy,
  output logic                    done,
  input  logic                    cpu_write,
  input  logic [7:0]              cpu_x,
  input  logic [7:0]              cpu_y,
  input  logic [BITSPERPIXEL-1:0] cpu_color,
  output logic [7:0]              fb_x,
  output logic [7:0]              fb_y,
  output logic [BITSPERPIXEL-1:0] fb_color,
  output logic                    fb_write
);
  typedef enum logic [1:0] {IDLE, SETUP, FILL, DONE} state_t;
  localparam logic [7:0] XMAX = 8'(WIDTH - 1);
  localparam logic [7:0] YMAX = 8'(HEIGHT - 1);
  state_t                  state_q, state_d;
  logic [7:0]              x0_q, x0_d, y0_q, y0_d, x1_q, x1_d, y1_q, y1_d;
  logic [7:0]              cx_q, cx_d, cy_q, cy_d;
  logic [BITSPERPIXEL-1:0] col_q, col_d;
  logic [7:0]              x1c, y1c;
  logic                    empty, fill_wr, cpu_sel;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      x0_q    <= '0;
      y0_q    <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      x0_q    <= x0_d;
      y0_q    <= y0_d;
      x1_q    <= x1_d;
      y1_q    <= y1_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      col_q   <= col_d;
    end
  end
  always_comb begin
    state_d = state_q;
    x0_d    = x0_q;
    y0_d    = y0_q;
    x1_d    = x1_q;
    y1_d    = y1_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    col_d   = col_q;
    fill_wr = 1'b0;
    x1c     = (x1_q > XMAX) ? XMAX : x1_q;
    y1c     = (y1_q > YMAX) ? YMAX : y1_q;
    empty   = (x0_q > x1c) || (y0_q > y1c) || (x0_q >= 8'(WIDTH)) || (y0_q >= 8'(HEIGHT));
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          x0_d    = x0;
          y0_d    = y0;
          x1_d    = x1;
          y1_d    = y1;
          col_d   = fill_color;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          x1_d    = x1c;
          y1_d    = y1c;
          cx_d    = x0_q;
          cy_d    = y0_q;
          state_d = empty ? DONE : FILL;
        end
      end
      FILL: begin
        if (abort) begin
          state_d = IDLE;
        end else if (!cpu_write) begin
          // x1_q/y1_q already hold the clamped corner once SETUP has run
          fill_wr = 1'b1;
          cx_d    = (cx_q == x1_q) ? x0_q : cx_q + 8'd1;
          cy_d    = (cx_q == x1_q) ? cy_q + 8'd1 : cy_q;
          state_d = (cx_q == x1_q && cy_q == y1_q) ? DONE : FILL;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  assign busy     = (state_q == SETUP) || (state_q == FILL);
  assign done     = (state_q == DONE);
  assign cpu_sel  = cpu_write && reset_n;
  assign fb_write = cpu_sel || fill_wr;
  assign fb_x     = cpu_sel ? cpu_x     : fill_wr ? cx_q  : '0;
  assign fb_y     = cpu_sel ? cpu_y     : fill_wr ? cy_q  : '0;
  assign fb_color = cpu_sel ? cpu_color : fill_wr ? col_q : '0;
endmodule

// File: tb/tb_rect_fill_ctrl.sv
// tb_rect_fill_ctrl: directed checks of fill sequencing, clipping, CPU stalls, abort and reset
module tb_rect_fill_ctrl;
  logic       clk = 0, reset_n = 0, start = 0, abort = 0, cpu_write = 0;
  logic [7:0] x0 = 0, y0 = 0, x1 = 0, y1 = 0, fill_color = 0;
  logic [7:0] cpu_x = 0, cpu_y = 0, cpu_color = 0;
  logic       busy, done, fb_write;
  logic [7:0] fb_x, fb_y, fb_color;
  logic [24:0] fb;
  int n_cmp = 0, n_err = 0;
  logic [7:0] ex6 [6] = '{8'd10, 8'd11, 8'd12, 8'd10, 8'd11, 8'd12};
  logic [7:0] ey6 [6] = '{8'd20, 8'd20, 8'd20, 8'd21, 8'd21, 8'd21};
  always #5 clk = ~clk;
  assign fb = {fb_write, fb_x, fb_y, fb_color};
  rect_fill_ctrl dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1), .fill_color(fill_color),
    .busy(busy), .done(done), .cpu_write(cpu_write), .cpu_x(cpu_x),
    .cpu_y(cpu_y), .cpu_color(cpu_color), .fb_x(fb_x), .fb_y(fb_y),
    .fb_color(fb_color), .fb_write(fb_write)
  );
  task automatic step();
    @(posedge clk);
    #2;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [24:0] px(input logic [7:0] x, input logic [7:0] y, input logic [7:0] c);
    return {1'b1, x, y, c};
  endfunction
  // leaves the bench settled in cycle 1 (SETUP) with start dropped
  task automatic go(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                    input logic [7:0] d, input logic [7:0] col);
    x0 = a; y0 = b; x1 = c; y1 = d; fill_color = col;
    start = 1;
    step();
    start = 0;
    #1;
  endtask
  initial begin
    int cnt, cyc;
    logic [24:0] last;
    cpu_write = 1; cpu_x = 8'h33; cpu_y = 8'h44; cpu_color = 8'h55;
    #3;
    chk("rst_fb_write", fb_write, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    cpu_write = 0;
    step();
    step();
    reset_n = 1;
    step();
    chk("idle_busy", busy, 0);
    go(10, 20, 12, 21, 8'hE0);
    chk("r6_setup_busy", busy, 1);
    chk("r6_setup_nowr", fb_write, 0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("r6_px", fb, px(ex6[i], ey6[i], 8'hE0));
      chk("r6_busy", busy, 1);
      chk("r6_done_lo", done, 0);
    end
    step();
    chk("r6_done", done, 1);
    chk("r6_done_busy", busy, 0);
    chk("r6_done_nowr", fb, 0);
    step();
    chk("r6_done_pulse", done, 0);
    go(5, 5, 4, 9, 8'h11);
    chk("inv_setup_busy", busy, 1);
    chk("inv_setup_nowr", fb_write, 0);
    step();
    chk("inv_done_c2", done, 1);
    chk("inv_nowr", fb_write, 0);
    step();
    chk("inv_done_pulse", done, 0);
    go(150, 115, 200, 255, 8'h3C);
    for (int y = 115; y <= 119; y++)
      for (int x = 150; x <= 159; x++) begin
        step();
        chk("clip_px", fb, px(8'(x), 8'(y), 8'h3C));
      end
    step();
    chk("clip_done", done, 1);
    chk("clip_nowr", fb_write, 0);
    step();
    go(0, 0, 159, 119, 8'h00);
    cnt = 0; cyc = 1; last = '0;
    while (!done && cyc < 20000) begin
      step();
      cyc++;
      if (fb_write) begin
        cnt++;
        last = fb;
      end
    end
    chk("clr_count", cnt, 19200);
    chk("clr_last", last, px(159, 119, 8'h00));
    chk("clr_done_cycle", cyc, 19202);
    step();
    go(10, 20, 12, 21, 8'hE0);
    step();
    chk("stall_px0", fb, px(10, 20, 8'hE0));
    step();
    chk("stall_px1", fb, px(11, 20, 8'hE0));
    step();
    cpu_write = 1; cpu_x = 3; cpu_y = 4; cpu_color = 8'h7F;
    #1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) step();
      chk("stall_cpu_px", fb, px(3, 4, 8'h7F));
      chk("stall_busy", busy, 1);
    end
    step();
    cpu_write = 0;
    #1;
    for (int i = 2; i < 6; i++) begin
      if (i > 2) step();
      chk("stall_resume_px", fb, px(ex6[i], ey6[i], 8'hE0));
    end
    step();
    chk("stall_done_c11", done, 1);
    step();
    go(10, 20, 12, 21, 8'hE0);
    step();
    chk("abt_px0", fb, px(10, 20, 8'hE0));
    step();
    chk("abt_px1", fb, px(11, 20, 8'hE0));
    step();
    abort = 1;
    #1;
    chk("abt_c4_nowr", fb_write, 0);
    step();
    abort = 0;
    #1;
    chk("abt_c5_busy", busy, 0);
    for (int i = 0; i < 4; i++) begin
      chk("abt_nowr", fb_write, 0);
      chk("abt_nodone", done, 0);
      step();
    end
    go(10, 20, 12, 21, 8'hE0);
    step();
    chk("rmid_px0", fb, px(10, 20, 8'hE0));
    cpu_write = 1;
    reset_n = 0;
    #1;
    chk("rmid_fb_write", fb_write, 0);
    chk("rmid_busy", busy, 0);
    cpu_write = 0;
    step();
    reset_n = 1;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("rmid_nowr", fb_write, 0);
      chk("rmid_idle", {busy, done}, 0);
      step();
    end
    go(10, 20, 12, 21, 8'hE0);
    step();
    chk("rest_px0", fb, px(10, 20, 8'hE0));
    step();
    x0 = 50; y0 = 50; x1 = 51; y1 = 51; fill_color = 8'hAA; start = 1;
    #1;
    chk("rest_px1", fb, px(11, 20, 8'hE0));
    step();
    start = 0;
    #1;
    for (int i = 2; i < 6; i++) begin
      if (i > 2) step();
      chk("rest_px", fb, px(ex6[i], ey6[i], 8'hE0));
    end
    step();
    chk("rest_done_c8", done, 1);
    step();
    chk("rest_idle_busy", busy, 0);
    step();
    chk("rest_no_restart", busy, 0);
    x0 = 1; y0 = 1; x1 = 2; y1 = 2; start = 1; abort = 1;
    step();
    start = 0; abort = 0;
    #1;
    chk("start_abort_idle", busy, 0);
    step();
    chk("start_abort_nowr", fb_write, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
